// File: rtl/spi_master_sched.sv
// Two-requester SPI master: round-robin arbitration, start bit, MSB-first payload,
// then a fixed ss-high gap. All outputs are registered and follow the state they enter.
module spi_master_sched #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        grant,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned BW   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t            state;
  logic              ptr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;

  logic              sel;
  logic              bit_end;
  logic              gap_end;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_next;

  assign sel     = req[ptr] ? ptr : ~ptr;
  assign bit_end = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign gap_end = (cyc_cnt == CW'(GAP_CYCLES - 1));
  // Truncating cast drops the old MSB, which keeps DATA_W == 1 legal.
  assign rx_next = DATA_W'({rx_sr, miso});
  assign tx_next = tx_sr << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      grant   <= '0;
      done    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state   <= START;
            grant   <= sel ? 2'b10 : 2'b01;
            ptr     <= ~sel;
            tx_sr   <= sel ? wdata1 : wdata0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            ss      <= 1'b0;
            mosi    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cyc_cnt <= '0;
            mosi    <= tx_sr[DATA_W-1];
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            rx_sr   <= rx_next;
            tx_sr   <= tx_next;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state   <= GAP;
              bit_cnt <= '0;
              rdata   <= rx_next;
              done    <= 1'b1;
              ss      <= 1'b1;
              mosi    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              mosi    <= tx_next[DATA_W-1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            grant   <= '0;
            busy    <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
